grad_mag_feeder: RTL and testbench

GRAD_MAG_FEEDER -- requirements
Module: grad_mag_feeder

---
 rtl/grad_mag_feeder.sv | 106 ++++++++++
 tb/tb_grad_mag_feeder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/grad_mag_feeder.sv
// Gradient magnitude-squared feeder: squares a {gy, gx} pair, sums, shifts and
// saturates into the cartesian input of a sqrt CORDIC, with frame/saturation stats.
module grad_mag_feeder #(
  parameter int GW    = 8,
  parameter int SHIFT = 0,
  parameter int OW    = 16
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              en,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [2*GW-1:0]   s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              m_axis_cartesian_tvalid,
  output logic [OW-1:0]     m_axis_cartesian_tdata,
  output logic              m_tlast,
  output logic              frame_done,
  output logic [15:0]       pix_cnt,
  output logic [15:0]       sat_cnt
);

  localparam int PW = 2 * GW;
  localparam int SW = PW + 1;
  localparam int XW = (SW > OW) ? SW : OW;
  localparam logic [XW:0] LIMIT = (XW + 1)'(1) << OW;

  logic                 accept;
  logic signed [GW-1:0] gx, gy;
  logic signed [PW-1:0] prod_x, prod_y;

  assign s_axis_tready = en & ~reset;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign gx            = s_axis_tdata[GW-1:0];
  assign gy            = s_axis_tdata[PW-1:GW];
  assign prod_x        = gx * gx;
  assign prod_y        = gy * gy;

  // Stage 1: squared components
  logic          v1;
  logic          last1;
  logic [PW-1:0] sq_x, sq_y;

  always_ff @(posedge aclk) begin
    if (reset) begin
      v1 <= 1'b0;
    end else begin
      v1 <= accept;
    end
    if (accept) begin
      sq_x  <= prod_x;
      sq_y  <= prod_y;
      last1 <= s_axis_tlast;
    end
  end

  // Stage 2: sum, shift, saturate
  logic [SW-1:0] sum;
  logic [XW-1:0] shifted;
  logic          sat;
  logic [OW-1:0] mag;
  logic          sat2;

  always_comb begin
    sum     = {1'b0, sq_x} + {1'b0, sq_y};
    shifted = XW'(sum >> SHIFT);
    sat     = {1'b0, shifted} >= LIMIT;
    mag     = sat ? '1 : OW'(shifted);
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      m_axis_cartesian_tvalid <= 1'b0;
      m_axis_cartesian_tdata  <= '0;
      m_tlast                 <= 1'b0;
      sat2                    <= 1'b0;
    end else begin
      m_axis_cartesian_tvalid <= v1;
      if (v1) begin
        m_axis_cartesian_tdata <= mag;
        m_tlast                <= last1;
        sat2                   <= sat;
      end
    end
  end

  // A beat arriving in the frame_done cycle starts the next frame at 1.
  always_ff @(posedge aclk) begin
    if (reset) begin
      frame_done <= 1'b0;
      pix_cnt    <= '0;
      sat_cnt    <= '0;
    end else begin
      frame_done <= m_axis_cartesian_tvalid & m_tlast;
      if (m_axis_cartesian_tvalid) begin
        pix_cnt <= (frame_done ? 16'd0 : pix_cnt) + 16'd1;
      end else if (frame_done) begin
        pix_cnt <= '0;
      end
      if (m_axis_cartesian_tvalid && sat2 && sat_cnt != 16'hFFFF) begin
        sat_cnt <= sat_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_grad_mag_feeder.sv
// Scoreboard bench for grad_mag_feeder: a default instance (OW=16) and an
// OW=14 instance share the stimulus; each has its own expected-output queue.
module tb_grad_mag_feeder;

  typedef struct {
    logic [15:0] d;
    logic        l;
    int          due;
  } exp_t;

  logic        aclk;
  logic        reset;
  logic        en;
  logic        s_axis_tvalid;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tlast;

  logic        rdy16, v16, l16, fd16;
  logic [15:0] d16, pix16, sat16;
  logic        rdy14, v14, l14, fd14;
  logic [13:0] d14;
  logic [15:0] pix14, sat14;

  exp_t q16[$];
  exp_t q14[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   fd_pulses = 0;

  grad_mag_feeder #(.GW(8), .SHIFT(0), .OW(16)) u16 (
    .aclk(aclk), .reset(reset), .en(en),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(rdy16),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_cartesian_tvalid(v16), .m_axis_cartesian_tdata(d16),
    .m_tlast(l16), .frame_done(fd16), .pix_cnt(pix16), .sat_cnt(sat16)
  );

  grad_mag_feeder #(.GW(8), .SHIFT(0), .OW(14)) u14 (
    .aclk(aclk), .reset(reset), .en(en),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(rdy14),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_cartesian_tvalid(v14), .m_axis_cartesian_tdata(d14),
    .m_tlast(l14), .frame_done(fd14), .pix_cnt(pix14), .sat_cnt(sat14)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;
  always @(negedge aclk) if (fd16) fd_pulses++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Output monitors: missed beats first, then the beat presented this cycle.
  always @(negedge aclk) begin
    while (q16.size() > 0 && q16[0].due < cyc) begin
      total++;
      $display("FAIL out16_missing: no output, expected %0d due cycle %0d", q16[0].d, q16[0].due);
      void'(q16.pop_front());
    end
    if (v16) begin
      total++;
      if (q16.size() == 0) begin
        $display("FAIL out16_unexpected: got %0d at cycle %0d, expected none", d16, cyc);
      end else begin
        exp_t e;
        e = q16.pop_front();
        if (d16 === e.d && l16 === e.l && cyc == e.due) passed++;
        else $display("FAIL out16: got %0d last=%0b cycle %0d expected %0d last=%0b cycle %0d",
                      d16, l16, cyc, e.d, e.l, e.due);
      end
    end
  end

  always @(negedge aclk) begin
    while (q14.size() > 0 && q14[0].due < cyc) begin
      total++;
      $display("FAIL out14_missing: no output, expected %0d due cycle %0d", q14[0].d, q14[0].due);
      void'(q14.pop_front());
    end
    if (v14) begin
      total++;
      if (q14.size() == 0) begin
        $display("FAIL out14_unexpected: got %0d at cycle %0d, expected none", d14, cyc);
      end else begin
        exp_t e;
        e = q14.pop_front();
        if ({2'b00, d14} === e.d && l14 === e.l && cyc == e.due) passed++;
        else $display("FAIL out14: got %0d last=%0b cycle %0d expected %0d last=%0b cycle %0d",
                      d14, l14, cyc, e.d, e.l, e.due);
      end
    end
  end

  task automatic beat(input int gx, input int gy, input logic last,
                      input logic [15:0] e16, input logic [15:0] e14, input bit push);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {8'(gy), 8'(gx)};
    s_axis_tlast  = last;
    if (push && en && !reset) begin
      q16.push_back('{d: e16, l: last, due: cyc + 2});
      q14.push_back('{d: e14, l: last, due: cyc + 2});
    end
    @(posedge aclk); #1;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tvalid", 32'(v16), 0);
    chk("rst_tdata", 32'(d16), 0);
    chk("rst_tlast", 32'(l16), 0);
    chk("rst_pix", 32'(pix16), 0);
    chk("rst_sat", 32'(sat16), 0);
    chk("rst_frame_done", 32'(fd16), 0);
    chk("rst_tready", 32'(rdy16), 0);

    // First accept right as reset releases
    @(posedge aclk); #1;
    reset = 1'b0; en = 1'b1;
    #1 chk("tready_en", 32'(rdy16), 1);
    beat(3, 4, 1'b0, 16'd25, 16'd25, 1'b1);
    idle(4);

    beat(-1, 0, 1'b0, 16'd1, 16'd1, 1'b1);
    beat(2, 0, 1'b0, 16'd4, 16'd4, 1'b1);
    beat(-3, 0, 1'b0, 16'd9, 16'd9, 1'b1);
    beat(127, 0, 1'b0, 16'd16129, 16'd16129, 1'b1);
    idle(4);
    chk("pix_after_5", 32'(pix16), 5);

    beat(127, 127, 1'b0, 16'd32258, 16'd16383, 1'b1);
    beat(-128, -128, 1'b1, 16'd32768, 16'd16383, 1'b1);
    idle(4);
    chk("sat14_cnt", 32'(sat14), 2);
    chk("sat16_cnt", 32'(sat16), 0);
    chk("pix_after_frame", 32'(pix16), 0);
    chk("fd_pulses_1", 32'(fd_pulses), 1);

    // Reset one cycle after an accept discards the in-flight beat
    beat(1, 1, 1'b0, 16'd2, 16'd2, 1'b1);
    idle(4);
    chk("pix_before_rst", 32'(pix16), 1);
    beat(127, 127, 1'b0, 16'd0, 16'd0, 1'b0);
    s_axis_tvalid = 1'b0;
    reset = 1'b1;
    @(posedge aclk); #1;
    reset = 1'b0;
    idle(4);
    chk("pix_after_rst", 32'(pix16), 0);
    chk("sat14_after_rst", 32'(sat14), 0);

    // Frame of three beats
    beat(1, 0, 1'b0, 16'd1, 16'd1, 1'b1);
    beat(0, 2, 1'b0, 16'd4, 16'd4, 1'b1);
    beat(-1, -1, 1'b1, 16'd2, 16'd2, 1'b1);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    @(negedge aclk); chk("frame_pix1", 32'(pix16), 1);
    @(negedge aclk); chk("frame_pix2", 32'(pix16), 2);
    @(negedge aclk); chk("frame_pix3", 32'(pix16), 3);
    chk("frame_done_hi", 32'(fd16), 1);
    @(negedge aclk); chk("frame_pix0", 32'(pix16), 0);
    chk("frame_done_lo", 32'(fd16), 0);
    chk("fd_pulses_2", 32'(fd_pulses), 2);
    @(posedge aclk); #1;

    // en drop: in-flight beat drains, held beat waits for en
    beat(2, 2, 1'b0, 16'd8, 16'd8, 1'b1);
    en = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = {8'd0, 8'd5};
    #1 chk("tready_stall", 32'(rdy16), 0);
    repeat (3) @(posedge aclk);
    #1;
    chk("pix_during_stall", 32'(pix16), 1);
    en = 1'b1;
    beat(5, 0, 1'b0, 16'd25, 16'd25, 1'b1);
    idle(5);
    chk("pix_final", 32'(pix16), 2);
    chk("q16_empty", 32'(q16.size()), 0);
    chk("q14_empty", 32'(q14.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
